// File: rtl/wb_struct_pkg.sv
// Shared Wishbone definitions: read-engine FSM states and CTI/BTE encodings.
// Also supplies default bus widths when the build does not predefine them.
`ifndef WB_ADDR_WIDTH
`define WB_ADDR_WIDTH 32
`endif
`ifndef WB_DATA_WIDTH
`define WB_DATA_WIDTH 32
`endif
`ifndef WB_SEL_WIDTH
`define WB_SEL_WIDTH 4
`endif

package wb_struct_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        BURST,
        FINISH
    } wb_rd_state_e;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_INCR    = 3'b010;
    localparam logic [2:0] WB_CTI_EOB     = 3'b111;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is shown combinationally
// from the head entry, so a pushed word is visible the cycle after the push.
module wb_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO may still take a word when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/wb_rd_burst_master.sv
// Wishbone incrementing-burst read engine feeding a valid/ready word stream.
// Define WB_ACK_TIMEOUT_EN to abort a burst after TIMEOUT stb cycles without ack.
module wb_rd_burst_master
    import wb_struct_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH = `WB_ADDR_WIDTH,
    parameter int unsigned WB_DATA_WIDTH = `WB_DATA_WIDTH,
    parameter int unsigned WB_SEL_WIDTH  = `WB_SEL_WIDTH,
    parameter int unsigned LEN_W         = 16,
    parameter int unsigned BURST_MAX     = 4,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned TIMEOUT       = 256
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [LEN_W-1:0]         req_len_i,
    output logic [WB_ADDR_WIDTH-1:0] m_wb_adr_o,
    output logic [WB_SEL_WIDTH-1:0]  m_wb_sel_o,
    output logic                     m_wb_we_o,
    input  logic [WB_DATA_WIDTH-1:0] m_wb_dat_i,
    output logic                     m_wb_cyc_o,
    output logic                     m_wb_stb_o,
    input  logic                     m_wb_ack_i,
    input  logic                     m_wb_err_i,
    output logic [2:0]               m_wb_cti_o,
    output logic [1:0]               m_wb_bte_o,
    output logic [WB_DATA_WIDTH-1:0] rd_data_o,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic                     done_o,
    output logic                     err_o
);
    localparam int unsigned BeatW = $clog2(BURST_MAX + 1);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < BURST_MAX || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT == 0)
    begin : g_cfg_check
        $error("wb_rd_burst_master: invalid FIFO_DEPTH/BURST_MAX/TIMEOUT");
    end

    wb_rd_state_e             state_q, state_d;
    logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]         remain_q, remain_d;
    logic [BeatW-1:0]         beats_q, beats_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic [LEN_W-1:0]         chunk, space;
    logic [CntW-1:0]          fifo_count;
    logic                     fifo_full, fifo_empty;
    logic                     bus_ack, bus_abort, tmo_hit;

`ifdef WB_ACK_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    logic [TmoW-1:0] tmo_q;

    assign tmo_hit = (state_q == BURST) && !m_wb_ack_i && (tmo_q == TmoW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            tmo_q <= '0;
        end else if (state_q != BURST || m_wb_ack_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Error beats are never pushed: an error outranks a simultaneous ack.
    assign bus_abort = (state_q == BURST) && (m_wb_err_i || tmo_hit);
    assign bus_ack   = (state_q == BURST) && m_wb_ack_i && !bus_abort;

    always_comb begin
        chunk = (remain_q < LEN_W'(BURST_MAX)) ? remain_q : LEN_W'(BURST_MAX);
        space = LEN_W'(FIFO_DEPTH) - LEN_W'(fifo_count);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        beats_d  = beats_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i & ~WB_ADDR_WIDTH'(3);
                    remain_d = req_len_i;
                    state_d  = (req_len_i == '0) ? FINISH : WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                // Reserve room for the whole chunk so the burst never stalls on a full FIFO.
                if (!fifo_full && space >= chunk) begin
                    beats_d = BeatW'(chunk);
                    state_d = BURST;
                end
            end
            BURST: begin
                if (bus_abort) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (bus_ack) begin
                    addr_d   = addr_q + WB_ADDR_WIDTH'(4);
                    remain_d = remain_q - 1'b1;
                    beats_d  = beats_q - 1'b1;
                    if (beats_q == BeatW'(1)) begin
                        state_d = (remain_q == LEN_W'(1)) ? FINISH : WAIT_SPACE;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            beats_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            beats_q  <= beats_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Bus strobes decode straight from the state register so reset drops them at once.
    assign req_ready_o = (state_q == IDLE);
    assign m_wb_cyc_o  = (state_q == BURST);
    assign m_wb_stb_o  = (state_q == BURST);
    assign m_wb_adr_o  = addr_q;
    assign m_wb_sel_o  = {WB_SEL_WIDTH{m_wb_cyc_o}};
    assign m_wb_we_o   = 1'b0;
    assign m_wb_bte_o  = WB_BTE_LINEAR;
    assign m_wb_cti_o  = !m_wb_cyc_o ? WB_CTI_CLASSIC :
                         (beats_q == BeatW'(1)) ? WB_CTI_EOB : WB_CTI_INCR;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rd_valid_o  = !fifo_empty;

    wb_sync_fifo #(
        .WIDTH (WB_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_n_i),
        .push_i  (bus_ack),
        .data_i  (m_wb_dat_i),
        .pop_i   (rd_valid_o && rd_ready_i),
        .data_o  (rd_data_o),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_wb_rd_burst_master.sv
// Randomized bench: a memory slave model answers bursts, a plan built from the
// request rules supplies expected bus beats and stream words.
`timescale 1ns/1ps
module tb_wb_rd_burst_master;
    localparam int unsigned BMAX  = 4;
    localparam int unsigned DEPTH = 8;
`ifdef WB_ACK_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 256;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic [15:0] req_len_i = '0;
    logic [31:0] m_wb_adr_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o;
    logic [31:0] m_wb_dat_i = '0;
    logic        m_wb_cyc_o, m_wb_stb_o;
    logic        m_wb_ack_i = 1'b0;
    logic        m_wb_err_i = 1'b0;
    logic [2:0]  m_wb_cti_o;
    logic [1:0]  m_wb_bte_o;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        rd_ready_i = 1'b0;
    logic        done_o, err_o;

    always #5 clk = ~clk;

    wb_rd_burst_master #(
        .TIMEOUT (TMO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_len_i   (req_len_i),
        .m_wb_adr_o  (m_wb_adr_o),
        .m_wb_sel_o  (m_wb_sel_o),
        .m_wb_we_o   (m_wb_we_o),
        .m_wb_dat_i  (m_wb_dat_i),
        .m_wb_cyc_o  (m_wb_cyc_o),
        .m_wb_stb_o  (m_wb_stb_o),
        .m_wb_ack_i  (m_wb_ack_i),
        .m_wb_err_i  (m_wb_err_i),
        .m_wb_cti_o  (m_wb_cti_o),
        .m_wb_bte_o  (m_wb_bte_o),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .rd_ready_i  (rd_ready_i),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1B7E};
    endfunction

    logic [31:0] exp_adr_q[$];
    logic [2:0]  exp_cti_q[$];
    logic [31:0] exp_word_q[$];

    // Expected beats split into chunks of at most BMAX; n_words of them reach the stream.
    task automatic plan(input logic [31:0] addr, input int len, input int n_words);
        logic [31:0] base;
        logic [31:0] a;
        int left;
        int chunk;
        base = {addr[31:2], 2'b00};
        a    = base;
        left = len;
        while (left > 0) begin
            chunk = (left < int'(BMAX)) ? left : int'(BMAX);
            for (int i = 0; i < chunk; i++) begin
                exp_adr_q.push_back(a);
                exp_cti_q.push_back((i == chunk - 1) ? 3'b111 : 3'b010);
                a = a + 32'd4;
            end
            left -= chunk;
        end
        for (int i = 0; i < n_words; i++) exp_word_q.push_back(mem_word(base + 32'(4 * i)));
    endtask

    int          ack_pct = 100;
    int          ready_pct = 100;
    int          err_beat = -1;
    int          beat_idx = 0;
    int          beats_seen = 0;
    int          words_seen = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          occ = 0;
    int          cyc_cnt = 0;
    int          first_stb = -1;
    int          last_done = -1;
    int          last_err = -1;
    bit          err_pending = 0;
    bit          eob_pending = 0;
    bit          stall_q = 0;
    logic [31:0] stall_data = '0;

    always @(posedge clk) cyc_cnt++;

    // Slave model, stream sink and protocol monitor, all acting at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_wb_ack_i  = 1'b0;
            m_wb_err_i  = 1'b0;
            err_pending = 0;
            eob_pending = 0;
            stall_q     = 0;
            occ         = 0;
        end else begin
            if (err_pending) begin
                check("cyc_drop_after_err", m_wb_cyc_o, 0);
                check("err_o_pulse", err_o, 1);
                err_pending = 0;
            end
            if (eob_pending) begin
                check("cyc_gap_after_eob", m_wb_cyc_o, 0);
                eob_pending = 0;
            end
            if (done_o) begin done_cnt++; last_done = cyc_cnt; end
            if (err_o) begin err_cnt++; last_err = cyc_cnt; end
            if (m_wb_stb_o && first_stb < 0) first_stb = cyc_cnt;

            m_wb_ack_i = 1'b0;
            m_wb_err_i = 1'b0;
            if (m_wb_cyc_o && m_wb_stb_o && $urandom_range(0, 99) < ack_pct) begin
                m_wb_dat_i = mem_word(m_wb_adr_o);
                m_wb_ack_i = 1'b1;
                if (beat_idx == err_beat) begin
                    m_wb_err_i  = 1'b1;
                    err_pending = 1;
                end else begin
                    beats_seen++;
                    occ++;
                    check("beat_expected", exp_adr_q.size() != 0, 1);
                    if (exp_adr_q.size() != 0) begin
                        check("beat_adr", m_wb_adr_o, exp_adr_q.pop_front());
                        check("beat_cti", m_wb_cti_o, exp_cti_q.pop_front());
                        check("beat_sel_bte", {m_wb_sel_o, m_wb_bte_o, m_wb_we_o}, 7'b1111_00_0);
                    end
                    eob_pending = (m_wb_cti_o == 3'b111);
                end
                beat_idx++;
            end

            if (stall_q) begin
                check("stall_valid", rd_valid_o, 1);
                check("stall_data", rd_data_o, stall_data);
            end
            rd_ready_i = ($urandom_range(0, 99) < ready_pct);
            if (rd_valid_o && rd_ready_i) begin
                words_seen++;
                occ--;
                check("word_expected", exp_word_q.size() != 0, 1);
                if (exp_word_q.size() != 0) check("word_data", rd_data_o, exp_word_q.pop_front());
            end
            stall_q    = rd_valid_o && !rd_ready_i;
            stall_data = rd_data_o;
            check("fifo_no_overflow", occ <= int'(DEPTH), 1);
        end
    end

    task automatic do_req(input logic [31:0] addr, input int len, output int acc_cyc);
        int n;
        @(negedge clk);
        req_addr_i  = addr;
        req_len_i   = 16'(len);
        req_valid_i = 1'b1;
        first_stb   = -1;
        n = 0;
        while (n < 50 && !req_ready_o) begin @(negedge clk); n++; end
        check("req_accepted", req_ready_o, 1);
        @(negedge clk);
        acc_cyc     = cyc_cnt;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (n < budget && !(req_ready_o && !rd_valid_o && exp_word_q.size() == 0)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_bound"}, n < budget, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic flush_model();
        exp_adr_q.delete();
        exp_cti_q.delete();
        exp_word_q.delete();
    endtask

    int acc, d0, e0, w0, b0, len;
    logic [31:0] addr;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready_o, 1);
        check("rst_cyc_stb", {m_wb_cyc_o, m_wb_stb_o}, 0);
        check("rst_adr", m_wb_adr_o, 0);
        check("rst_sel_cti_bte_we", {m_wb_sel_o, m_wb_cti_o, m_wb_bte_o, m_wb_we_o}, 0);
        check("rst_stream", {rd_valid_o, rd_data_o}, 0);
        check("rst_done_err", {done_o, err_o}, 0);
        rst_n = 1'b1;

        // Basic fetch: two bursts of 4 and 2 beats.
        ack_pct = 100; ready_pct = 100;
        d0 = done_cnt; w0 = words_seen;
        plan(32'h1000, 6, 6);
        do_req(32'h1000, 6, acc);
        wait_idle(200, "basic");
        check("basic_first_stb_lat", first_stb - acc, 1);
        check("basic_words", words_seen - w0, 6);
        check("basic_done", done_cnt - d0, 1);
        check("basic_beats_left", exp_adr_q.size(), 0);

        // Zero length: done in the second cycle after the request cycle, no bus cycle.
        d0 = done_cnt;
        plan(32'h1234, 0, 0);
        do_req(32'h1234, 0, acc);
        wait_idle(50, "zero");
        check("zero_no_stb", first_stb, -1);
        check("zero_done_lat", last_done - acc, 1);
        check("zero_done", done_cnt - d0, 1);

        // Backpressure: FIFO fills to DEPTH, then bus stays idle until the sink drains.
        ready_pct = 0;
        d0 = done_cnt; w0 = words_seen; b0 = beats_seen;
        plan(32'h2002, 12, 12);
        do_req(32'h2002, 12, acc);
        repeat (60) @(negedge clk);
        check("bp_beats_capped", beats_seen - b0, DEPTH);
        check("bp_no_words", words_seen - w0, 0);
        check("bp_cyc_low", m_wb_cyc_o, 0);
        check("bp_valid", rd_valid_o, 1);
        ready_pct = 100;
        wait_idle(300, "bp");
        check("bp_words", words_seen - w0, 12);
        check("bp_done", done_cnt - d0, 1);

        // Error with a simultaneous ack on beat 3 of the first burst.
        d0 = done_cnt; e0 = err_cnt; w0 = words_seen;
        beat_idx = 0; err_beat = 2;
        plan(32'h3000, 8, 2);
        do_req(32'h3000, 8, acc);
        wait_idle(200, "err");
        err_beat = -1;
        check("err_pulses", err_cnt - e0, 1);
        check("err_no_done", done_cnt - d0, 0);
        check("err_words", words_seen - w0, 2);
        check("err_req_ready", req_ready_o, 1);
        check("err_beats_left", exp_adr_q.size(), 6);
        flush_model();

        // Asynchronous reset while beat 2 is on the bus.
        ready_pct = 0; beat_idx = 0;
        plan(32'h4000, 8, 8);
        do_req(32'h4000, 8, acc);
        for (int i = 0; i < 50 && !(beat_idx == 2 && m_wb_stb_o); i++) begin
            @(negedge clk);
            #1;
        end
        check("rst_mid_reached_beat2", beat_idx, 2);
        check("rst_mid_valid_before", rd_valid_o, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_cyc_stb", {m_wb_cyc_o, m_wb_stb_o}, 0);
        check("rst_mid_valid", rd_valid_o, 0);
        check("rst_mid_req_ready", req_ready_o, 1);
        @(negedge clk);
        @(negedge clk);
        flush_model();
        rst_n = 1'b1;
        ready_pct = 100;
        d0 = done_cnt; w0 = words_seen;
        plan(32'h5000, 1, 1);
        do_req(32'h5000, 1, acc);
        wait_idle(100, "after_rst");
        check("after_rst_words", words_seen - w0, 1);
        check("after_rst_done", done_cnt - d0, 1);

`ifdef WB_ACK_TIMEOUT_EN
        // Withheld ack: abort once stb has been high for TMO cycles.
        ack_pct = 0; e0 = err_cnt;
        plan(32'h6000, 2, 0);
        do_req(32'h6000, 2, acc);
        wait_idle(100, "tmo");
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_latency", last_err - first_stb, TMO);
        check("tmo_cyc_low", m_wb_cyc_o, 0);
        flush_model();
        ack_pct = 100;
`endif

        // Random requests, including one crossing the top of the address space.
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 12; i++) begin
            addr = (i == 0) ? 32'hFFFF_FFF6 : $urandom;
            len  = (i == 0) ? 7 : int'($urandom_range(0, 20));
            ack_pct   = int'($urandom_range(40, 100));
            ready_pct = int'($urandom_range(20, 100));
            w0 = words_seen;
            plan(addr, len, len);
            do_req(addr, len, acc);
            wait_idle(3000, "rand");
            check("rand_words", words_seen - w0, len);
            check("rand_beats_left", exp_adr_q.size(), 0);
        end
        check("rand_done", done_cnt - d0, 12);
        check("rand_no_err", err_cnt - e0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
